signed_mult_scheduler: RTL and testbench

SIGNED_MULT_SCHEDULER -- requirements
Module: signed_mult_scheduler

---
 rtl/signed_mult_scheduler_pkg.sv | 14 +
 rtl/signed_mult_scheduler_booth.sv | 55 +++++
 rtl/signed_mult_scheduler.sv | 119 +++++++++++
 tb/tb_signed_mult_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/signed_mult_scheduler_pkg.sv
// signed_mult_scheduler_pkg
//   Shared definitions for the two-requester signed Booth multiplier
//   scheduler: the controller state encoding and the default operand width.
package signed_mult_scheduler_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/signed_mult_scheduler_booth.sv
// booth_mult_core
//   Sequential radix-2 Booth multiplier datapath. One recoding step per
//   cycle while step is high; WIDTH steps produce the full signed product.
//   Ports:
//     clk      - clock
//     start    - load operands and clear the accumulator
//     step     - perform one Booth add/sub + arithmetic shift
//     a, b     - signed multiplicand / multiplier (sampled on start)
//     product  - {accumulator, multiplier register}, valid after WIDTH steps
module booth_mult_core #(
    parameter int WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      start,
    input  logic                      step,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] product
);

    // One guard bit on the accumulator and multiplicand so that
    // subtracting the most-negative multiplicand cannot overflow.
    logic signed [WIDTH:0]   acc;
    logic signed [WIDTH:0]   mcand;
    logic        [WIDTH-1:0] q;
    logic                    q_m1;
    logic signed [WIDTH:0]   sum;

    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
    end

    // Datapath registers carry no reset: start always reloads them before use.
    always_ff @(posedge clk) begin
        if (start) begin
            acc   <= '0;
            mcand <= {a[WIDTH-1], a};
            q     <= b;
            q_m1  <= 1'b0;
        end else if (step) begin
            acc   <= sum >>> 1;
            q     <= {sum[0], q[WIDTH-1:1]};
            q_m1  <= q[0];
        end
    end

    // The exact product fits in 2*WIDTH bits, so the guard bit is dropped.
    assign product = {acc[WIDTH-1:0], q};

endmodule

// File: rtl/signed_mult_scheduler.sv
// signed_mult_scheduler
//   Shares one sequential Booth multiplier between two requesters.
//   Acceptance happens only in IDLE; simultaneous requests are arbitrated
//   round-robin. A result is held in DONE until the consumer takes it.
//   Ports:
//     clk, rst_n                 - clock, asynchronous active-low reset
//     reqN_valid/reqN_a/reqN_b   - requester N operand pair (N = 0, 1)
//     reqN_ready                 - requester N accepted this cycle
//     res_valid/res_id/res_product - result, owner index, signed product
//     res_ready                  - consumer takes the result this cycle
module signed_mult_scheduler
    import signed_mult_scheduler_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0_valid,
    input  logic signed [WIDTH-1:0]   req0_a,
    input  logic signed [WIDTH-1:0]   req0_b,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic signed [WIDTH-1:0]   req1_a,
    input  logic signed [WIDTH-1:0]   req1_b,
    output logic                      req1_ready,
    output logic                      res_valid,
    output logic                      res_id,
    output logic signed [2*WIDTH-1:0] res_product,
    input  logic                      res_ready
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic                      rr_ptr;
    logic                      grant;
    logic                      accept;
    logic                      consume;
    logic                      cur_id;
    logic                      held_id;
    logic signed [2*WIDTH-1:0] core_product;
    logic signed [2*WIDTH-1:0] held_product;
    logic signed [WIDTH-1:0]   sel_a;
    logic signed [WIDTH-1:0]   sel_b;

    // A lone requester wins outright; a tie goes to the round-robin pointer.
    always_comb begin
        grant = rr_ptr;
        if (req0_valid ^ req1_valid)
            grant = req1_valid;
    end

    // Readys are gated by rst_n so they read 0 for the whole reset window.
    assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant;
    assign accept     = req0_ready || req1_ready;
    assign consume    = (state == DONE) && res_ready;

    assign sel_a = grant ? req1_a : req0_a;
    assign sel_b = grant ? req1_b : req0_b;

    booth_mult_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .start   (accept),
        .step    (state == RUN),
        .a       (sel_a),
        .b       (sel_b),
        .product (core_product)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)            state_nxt = RUN;
            RUN:     if (cnt == LAST_STEP)  state_nxt = DONE;
            DONE:    if (res_ready)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            rr_ptr       <= 1'b0;
            cur_id       <= 1'b0;
            held_id      <= 1'b0;
            held_product <= '0;
        end else begin
            if (accept) begin
                cnt    <= '0;
                rr_ptr <= ~grant;
                cur_id <= grant;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
            end
            if (consume) begin
                held_id      <= cur_id;
                held_product <= core_product;
            end
        end
    end

    // Outside DONE the last consumed result is shown, so in-flight core
    // activity never disturbs the result outputs.
    assign res_valid   = (state == DONE);
    assign res_id      = (state == DONE) ? cur_id       : held_id;
    assign res_product = (state == DONE) ? core_product : held_product;

endmodule

// File: tb/tb_signed_mult_scheduler.sv
module tb_signed_mult_scheduler;

    localparam int W  = 3;
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          req0_ready, req1_ready;
    logic          res_valid, res_id, res_ready;
    logic [PW-1:0] res_product;

    int checks = 0;
    int errors = 0;

    signed_mult_scheduler #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ready  (req1_ready),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_product (res_product),
        .res_ready   (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "global time limit expired");
    end

    // Reference: plain integer multiplication of the sign-extended operands.
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return PW'(sa * sb);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for res_valid; returns the number of edges since the accept edge.
    task automatic wait_result(output int lat);
        lat = 0;
        while (res_valid !== 1'b1 && lat < 12) begin
            step();
            lat++;
        end
    endtask

    // One transaction from a single requester; hold = cycles the consumer stalls.
    task automatic transact(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [PW-1:0] exp_p;
        int lat;
        exp_p = ref_mul(a, b);
        res_ready = (hold == 0);
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
        #1;
        chk("ready_own",   (id == 0) ? req0_ready : req1_ready, 1);
        chk("ready_other", (id == 0) ? req1_ready : req0_ready, 0);
        step();
        // Operand changes after acceptance must not reach the result.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = W'($urandom); req0_b = W'($urandom);
        req1_a = W'($urandom); req1_b = W'($urandom);
        #1;
        chk("ready_after_accept", {req0_ready, req1_ready}, 0);
        wait_result(lat);
        chk("latency", lat, 3);
        chk("product", res_product, exp_p);
        chk("id", res_id, id);
        for (int h = 0; h < hold; h++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            step();
            chk("hold_valid", res_valid, 1);
            chk("hold_product", res_product, exp_p);
            chk("hold_id", res_id, id);
            chk("hold_readys", {req0_ready, req1_ready}, 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        res_ready = 1'b1;
        step();
        chk("consumed", res_valid, 0);
        chk("idle_product_held", res_product, exp_p);
    endtask

    initial begin
        logic [W-1:0] o0a, o0b, o1a, o1b, ga, gb;
        logic [PW-1:0] exp_p;
        int lat;

        // Reset state, with both requesters asserting valid.
        rst_n = 1'b0; res_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 3'd1; req0_b = 3'd2; req1_a = 3'd3; req1_b = 3'd1;
        step(); step();
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_product", res_product, 0);
        chk("rst_readys", {req0_ready, req1_ready}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // req0 only: 3 x -2 = -6.
        transact(0, 3'd3, 3'b110, 0);
        // req1 only: -4 x -4 = +16.
        transact(1, 3'b100, 3'b100, 0);

        // All 64 operand pairs from a random requester with random stalls.
        for (int i = 0; i < 64; i++) begin
            logic [5:0] iv;
            iv = 6'(i);
            transact(int'($urandom_range(0, 1)), iv[5:3], iv[2:0], int'($urandom_range(0, 2)));
        end

        // Stall of 5 cycles in DONE.
        transact(0, 3'b101, 3'd3, 5);

        // Both valid from reset: grants alternate 0,1,0,1 starting at 0.
        rst_n = 1'b0;
        res_ready = 1'b1;
        o0a = W'($urandom); o0b = W'($urandom);
        o1a = W'($urandom); o1b = o0b ^ W'($urandom_range(1, 7));
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = o0a; req0_b = o0b; req1_a = o1a; req1_b = o1b;
        step();
        rst_n = 1'b1;
        #1;
        for (int g = 0; g < 6; g++) begin
            chk("rr_grant0", req0_ready, (g % 2 == 0));
            chk("rr_grant1", req1_ready, (g % 2 == 1));
            ga = (g % 2 == 0) ? req0_a : req1_a;
            gb = (g % 2 == 0) ? req0_b : req1_b;
            exp_p = ref_mul(ga, gb);
            step();
            o0a = W'($urandom); o0b = W'($urandom);
            o1a = W'($urandom); o1b = o0b ^ W'($urandom_range(1, 7));
            req0_a = o0a; req0_b = o0b; req1_a = o1a; req1_b = o1b;
            wait_result(lat);
            chk("rr_latency", lat, 3);
            chk("rr_product", res_product, exp_p);
            chk("rr_id", res_id, g % 2);
            step();
            chk("rr_consumed", res_valid, 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Reset pulse during the second RUN cycle discards the operation.
        transact(1, 3'd3, 3'd3, 0);
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 3'd2; req0_b = 3'd3;
        step();
        req0_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_id", res_id, 0);
        chk("abort_res_product", res_product, 0);
        chk("abort_readys", {req0_ready, req1_ready}, 0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("abort_no_result", res_valid, 0);
        end
        transact(0, 3'b101, 3'd2, 1);
        transact(1, 3'b011, 3'b100, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
